// File: rtl/immediate_packer_if.sv
// Request/response bundle for the immediate packer: field inputs with a
// valid/ready handshake on the request side, packed word plus error status on the output side.
interface immediate_packer_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_format;
  logic [6:0]   in_opcode;
  logic [4:0]   in_rd;
  logic [4:0]   in_rs1;
  logic [4:0]   in_rs2;
  logic [2:0]   in_funct3;
  logic [6:0]   in_funct7;
  logic [N-1:0] in_immediate;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_instruction;
  logic         out_error;
  logic [7:0]   error_count;

  // The program builder drives requests and consumes words.
  modport master (
    output in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_immediate, out_ready,
    input  in_ready, out_valid, out_instruction, out_error, error_count
  );

  // The packer accepts requests and produces words.
  modport slave (
    input  in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_immediate, out_ready,
    output in_ready, out_valid, out_instruction, out_error, error_count
  );
endinterface

// File: rtl/immediate_packer.sv
// Packs a sign-extended immediate and register/funct/opcode fields into an
// RV32I instruction word through a two-stage elastic pipeline.
module immediate_packer #(
  parameter int N = 64
) (
  input logic               clock,
  input logic               reset,
  immediate_packer_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic        s1_valid;
  logic [2:0]  s1_format;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;
  logic        s1_error;

  logic        s2_valid;
  logic [31:0] s2_instruction;
  logic        s2_error;
  logic [7:0]  error_count;

  logic        s1_advance;
  logic        s2_advance;
  logic        range_error;
  logic [31:0] packed_word;

  logic upper11_same;
  logic upper12_same;
  logic upper20_same;
  logic upper31_same;

  assign s2_advance = ~s2_valid | bus.out_ready;
  assign s1_advance = ~s1_valid | s2_advance;

  // An immediate fits a k-bit field when every bit above it repeats the field's sign bit.
  assign upper11_same = (&bus.in_immediate[N-1:11]) | ~(|bus.in_immediate[N-1:11]);
  assign upper12_same = (&bus.in_immediate[N-1:12]) | ~(|bus.in_immediate[N-1:12]);
  assign upper20_same = (&bus.in_immediate[N-1:20]) | ~(|bus.in_immediate[N-1:20]);
  assign upper31_same = (&bus.in_immediate[N-1:31]) | ~(|bus.in_immediate[N-1:31]);

  always_comb begin
    range_error = 1'b0;
    case (bus.in_format)
      FMT_R:        range_error = 1'b0;
      FMT_I, FMT_S: range_error = ~upper11_same;
      FMT_B:        range_error = bus.in_immediate[0] | ~upper12_same;
      FMT_U:        range_error = (|bus.in_immediate[11:0]) | ~upper31_same;
      FMT_J:        range_error = bus.in_immediate[0] | ~upper20_same;
      default:      range_error = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_format <= '0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
      s1_error  <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_format <= bus.in_format;
        s1_opcode <= bus.in_opcode;
        s1_rd     <= bus.in_rd;
        s1_rs1    <= bus.in_rs1;
        s1_rs2    <= bus.in_rs2;
        s1_funct3 <= bus.in_funct3;
        s1_funct7 <= bus.in_funct7;
        s1_imm    <= bus.in_immediate[31:0];
        s1_error  <= range_error;
      end
    end
  end

  // Out-of-range immediates are still packed from their truncated bits.
  always_comb begin
    packed_word = '0;
    case (s1_format)
      FMT_R: packed_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                            s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                            s1_rd, s1_opcode};
      default: packed_word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid       <= 1'b0;
      s2_instruction <= '0;
      s2_error       <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instruction <= packed_word;
        s2_error       <= s1_error;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      error_count <= '0;
    end else if (s2_valid && bus.out_ready && s2_error && (error_count != 8'hFF)) begin
      error_count <= error_count + 8'd1;
    end
  end

  assign bus.in_ready        = s1_advance;
  assign bus.out_valid       = s2_valid;
  assign bus.out_instruction = s2_instruction;
  assign bus.out_error       = s2_error;
  assign bus.error_count     = error_count;

endmodule

// File: tb/tb_immediate_packer.sv
// Self-checking bench for immediate_packer: directed cases plus randomized
// traffic scored against an arithmetic reference of the packing rules.
module tb_immediate_packer;

  localparam int N = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  immediate_packer_if #(.N(N)) bus ();

  immediate_packer #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          cycle;
  } del_t;

  exp_t exp_q[$];
  del_t delivered[$];

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   model_count = 0;
  int   last_accept_cycle = 0;
  bit   rand_ready = 1'b0;

  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr = '0;
  logic        prev_err = 1'b0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: range limits expressed as signed intervals on the immediate value.
  function automatic exp_t model_pack(input logic [2:0] fmt, input logic [6:0] op,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [63:0] imm);
    exp_t   e;
    longint v;
    logic [31:0] w;
    v = longint'(imm);
    w = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
    e.err = 1'b0;
    case (fmt)
      3'd0: e.instr = w | (32'(f7) << 25);
      3'd1: begin
        e.err   = (v < -64'sd2048) || (v > 64'sd2047);
        e.instr = (w & 32'h000F_FFFF & ~(32'h1F << 20)) | (32'(imm[11:0]) << 20);
      end
      3'd2: begin
        e.err   = (v < -64'sd2048) || (v > 64'sd2047);
        e.instr = (w & ~(32'h1F << 7)) | (32'(imm[4:0]) << 7) | (32'(imm[11:5]) << 25);
      end
      3'd3: begin
        e.err   = imm[0] || (v < -64'sd4096) || (v > 64'sd4095);
        e.instr = (w & ~(32'h1F << 7)) | (32'(imm[11]) << 7) | (32'(imm[4:1]) << 8)
                  | (32'(imm[10:5]) << 25) | (32'(imm[12]) << 31);
      end
      3'd4: begin
        e.err   = (imm[11:0] != 12'd0) || (v < -64'sd2147483648) || (v > 64'sd2147483647);
        e.instr = (w & 32'h0000_0FFF) | (imm[31:0] & 32'hFFFF_F000);
      end
      3'd5: begin
        e.err   = imm[0] || (v < -64'sd1048576) || (v > 64'sd1048575);
        e.instr = (w & 32'h0000_0FFF) | (32'(imm[19:12]) << 12) | (32'(imm[11]) << 20)
                  | (32'(imm[10:1]) << 21) | (32'(imm[20]) << 31);
      end
      default: begin
        e.err   = 1'b1;
        e.instr = 32'h0000_0000;
      end
    endcase
    return e;
  endfunction

  // Output scoreboard, hold-stability check and error-count model.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      model_count = 0;
      prev_stall  = 1'b0;
    end else begin
      check_output("error_count", 64'(bus.error_count), 64'(model_count));
      if (prev_stall) begin
        check_output("hold_valid", 64'(bus.out_valid), 64'd1);
        check_output("hold_instr", 64'(bus.out_instruction), 64'(prev_instr));
        check_output("hold_error", 64'(bus.out_error), 64'(prev_err));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_word", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("word", 64'(bus.out_instruction), 64'(e.instr));
          check_output("word_error", 64'(bus.out_error), 64'(e.err));
        end
        delivered.push_back('{bus.out_instruction, bus.out_error, cycle});
        if (bus.out_error && model_count < 255) model_count++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_instr = bus.out_instruction;
      prev_err   = bus.out_error;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic apply_stimulus(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [63:0] imm);
    int   budget = 200;
    logic acc = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_format    = fmt;
    bus.in_opcode    = op;
    bus.in_rd        = rd;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_funct3    = f3;
    bus.in_funct7    = f7;
    bus.in_immediate = imm;
    do begin
      @(negedge clock);
      acc = bus.in_ready;
      if (acc) last_accept_cycle = cycle;
      @(posedge clock);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      budget--;
    end while (!acc && budget > 0);
    if (acc) exp_q.push_back(model_pack(fmt, op, rd, rs1, rs2, f3, f7, imm));
    else check_output("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 300;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clock);
      #1;
      budget--;
    end
    if (exp_q.size() != 0) check_output("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] random_imm();
    logic [63:0] bounds [14] = '{64'hFFFF_FFFF_FFFF_F800, 64'd2047, 64'd2048,
                                 64'hFFFF_FFFF_FFFF_F7FF, 64'hFFFF_FFFF_FFFF_F000, 64'd4094,
                                 64'd4096, 64'hFFFF_FFFF_FFFF_EFFE, 64'd1048574, 64'd1048576,
                                 64'hFFFF_FFFF_FFF0_0000, 64'h7FFF_F000,
                                 64'hFFFF_FFFF_8000_0000, 64'h8000_0000};
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: return 64'(longint'($urandom_range(0, 80)) - 64'sd40);
      1: return bounds[$urandom_range(0, 13)];
      2: return {$urandom(), $urandom()};
      default: begin
        t = $urandom();
        t[11:0] = 12'd0;
        return {{32{t[31]}}, t};
      end
    endcase
  endfunction

  initial begin
    int   base;
    exp_t held;
    exp_t bp_exp [5];
    bus.in_valid     = 1'b0;
    bus.in_format    = '0;
    bus.in_opcode    = '0;
    bus.in_rd        = '0;
    bus.in_rs1       = '0;
    bus.in_rs2       = '0;
    bus.in_funct3    = '0;
    bus.in_funct7    = '0;
    bus.in_immediate = '0;
    bus.out_ready    = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check_output("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("reset_out_instr", 64'(bus.out_instruction), 64'd0);
    check_output("reset_out_error", 64'(bus.out_error), 64'd0);
    check_output("reset_error_count", 64'(bus.error_count), 64'd0);
    reset = 1'b0;
    check_output("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // I-type and latency
    bus.out_ready = 1'b1;
    base = delivered.size();
    apply_stimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    check_output("i_count", 64'(delivered.size() - base), 64'd1);
    check_output("i_instr", 64'(delivered[base].instr), 64'hFFF0_0093);
    check_output("i_error", 64'(delivered[base].err), 64'd0);
    check_output("i_latency", 64'(delivered[base].cycle - last_accept_cycle), 64'd2);

    // S then B back-to-back
    base = delivered.size();
    apply_stimulus(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd3, 7'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    apply_stimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd8);
    drain();
    check_output("sb_count", 64'(delivered.size() - base), 64'd2);
    check_output("s_instr", 64'(delivered[base].instr), 64'hFE21_BC23);
    check_output("b_instr", 64'(delivered[base+1].instr), 64'h0020_8463);
    check_output("sb_consecutive", 64'(delivered[base+1].cycle - delivered[base].cycle), 64'd1);

    // U and J
    base = delivered.size();
    apply_stimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);
    apply_stimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
    drain();
    check_output("u_instr", 64'(delivered[base].instr), 64'h1234_52B7);
    check_output("u_error", 64'(delivered[base].err), 64'd0);
    check_output("j_instr", 64'(delivered[base+1].instr), 64'h0010_00EF);
    check_output("j_error", 64'(delivered[base+1].err), 64'd0);

    // Range and format errors
    base = delivered.size();
    apply_stimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3);
    apply_stimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
    apply_stimulus(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 64'd0);
    drain();
    check_output("b_odd_error", 64'(delivered[base].err), 64'd1);
    check_output("i_2048_error", 64'(delivered[base+1].err), 64'd1);
    check_output("fmt7_instr", 64'(delivered[base+2].instr), 64'h0000_0000);
    check_output("fmt7_error", 64'(delivered[base+2].err), 64'd1);
    check_output("error_count_three", 64'(bus.error_count), 64'd3);

    // Backpressure: pipeline fills after two accepts, then holds
    base = delivered.size();
    bus.out_ready = 1'b0;
    apply_stimulus(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd1, 64'd0);
    apply_stimulus(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 7'd2, 64'd0);
    for (int i = 0; i < 2; i++) bp_exp[i] = exp_q[i];
    check_output("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    held = exp_q[0];
    bus.in_valid     = 1'b1;
    bus.in_format    = 3'd0;
    bus.in_opcode    = 7'h33;
    bus.in_funct7    = 7'd3;
    repeat (4) begin
      check_output("bp_stall_ready", 64'(bus.in_ready), 64'd0);
      check_output("bp_stall_valid", 64'(bus.out_valid), 64'd1);
      check_output("bp_stall_instr", 64'(bus.out_instruction), 64'(held.instr));
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    apply_stimulus(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd2, 7'd3, 64'd0);
    apply_stimulus(3'd1, 7'h13, 5'd10, 5'd11, 5'd0, 3'd3, 7'd0, 64'd100);
    apply_stimulus(3'd4, 7'h17, 5'd12, 5'd0, 5'd0, 3'd0, 7'd0, 64'hABCD_E000);
    bp_exp[2] = model_pack(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd2, 7'd3, 64'd0);
    bp_exp[3] = model_pack(3'd1, 7'h13, 5'd10, 5'd11, 5'd0, 3'd3, 7'd0, 64'd100);
    bp_exp[4] = model_pack(3'd4, 7'h17, 5'd12, 5'd0, 5'd0, 3'd0, 7'd0, 64'hABCD_E000);
    drain();
    check_output("bp_count", 64'(delivered.size() - base), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < delivered.size())
        check_output("bp_order", 64'(delivered[base+i].instr), 64'(bp_exp[i].instr));
    end

    // Randomized traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      apply_stimulus(3'($urandom_range(0, 7)), 7'($urandom()), 5'($urandom()),
                     5'($urandom()), 5'($urandom()), 3'($urandom()), 7'($urandom()),
                     random_imm());
    end
    rand_ready = 1'b0;
    drain();

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(3'd6, 7'($urandom()), 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    end
    drain();
    check_output("error_count_saturated", 64'(bus.error_count), 64'd255);

    // Reset with both stages full flushes everything
    bus.out_ready = 1'b0;
    apply_stimulus(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'd5);
    apply_stimulus(3'd7, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 64'd6);
    check_output("full_in_ready", 64'(bus.in_ready), 64'd0);
    check_output("full_out_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_output("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("flush_error_count", 64'(bus.error_count), 64'd0);
    check_output("flush_out_instr", 64'(bus.out_instruction), 64'd0);
    reset = 1'b0;
    base = delivered.size();
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check_output("flush_no_stale", 64'(delivered.size() - base), 64'd0);

    base = delivered.size();
    apply_stimulus(3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 64'd7);
    drain();
    check_output("post_reset_count", 64'(delivered.size() - base), 64'd1);
    if (delivered.size() > base)
      check_output("post_reset_instr", 64'(delivered[base].instr), 64'h0072_0193);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
